axi_ts_measure_arb: RTL and testbench

- Arbitrates one shared measurement device among N trigger-subsystem cores, each owning a measure_start/ready/done handshake.
- Sits between the per-channel trigger cores and the single device action interface.
- Grants one requester at a time, round-robin, and forwards the handshake.
- Captures an RTC timestamp at device acceptance and enforces a busy timeout.

---
 rtl/axi_ts_pkg.sv | 21 ++
 rtl/axi_ts_rr_pick.sv | 37 +++
 rtl/axi_ts_measure_arb.sv | 139 +++++++++++++
 tb/tb_axi_ts_measure_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ts_pkg.sv
// Shared types and helpers for the measurement-device arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_ts_pkg;

    // Largest requester count the arbiter is built and verified for.
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } ARB_STATE_T;

    // Index width that never collapses to zero bits for tiny counts.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi_ts_rr_pick.sv
// Round-robin picker: first set request at or above rr_ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; valid is low when no request is set.
//
// Ports:
//   req    - request vector, one bit per requester
//   rr_ptr - highest-priority index for this pick
//   valid  - at least one request set
//   index  - chosen requester
module axi_ts_rr_pick import axi_ts_pkg::*; #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = safe_clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             valid,
    output logic [ID_W-1:0]  index
);

    logic [ID_W-1:0] cand;

    // Scan offsets from farthest to nearest; the nearest set bit is written
    // last and therefore wins, giving a priority chain without a break.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = ID_W'((int'(rr_ptr) + off) % N_REQ);
            if (req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/axi_ts_measure_arb.sv
// Shares one measurement device among N_REQ trigger cores, round-robin, with RTC stamp and busy timeout.
// Latency: dev_start 1 cycle after req_start; req_ready/req_done 1 cycle after dev_ready/dev_done.
// Backpressure: requesters hold req_start until req_ready; dev_start is held until dev_ready.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rtc_sec, rtc_nsec   - free-running RTC, sampled when the device accepts
//   ctrl_abort          - drop the current grant silently and return to IDLE
//   req_start           - per-requester start level
//   req_ready, req_done - per-requester one-cycle pulses; req_error qualifies req_done
//   dev_start/ready/done- device action handshake
//   grant_id            - current or last owner
//   grant_sec/nsec      - RTC captured at device acceptance
//   stat_busy           - grant outstanding (GRANT or BUSY)
//   stat_timeout        - sticky: a busy timeout has happened since reset
module axi_ts_measure_arb import axi_ts_pkg::*; #(
    parameter  int N_REQ          = 4,
    parameter  int TIMEOUT_CYCLES = 1000000,
    parameter  int CNT_W          = 32,
    localparam int ID_W           = safe_clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       rtc_sec,
    input  logic [31:0]       rtc_nsec,
    input  logic              ctrl_abort,
    input  logic [N_REQ-1:0]  req_start,
    output logic [N_REQ-1:0]  req_ready,
    output logic [N_REQ-1:0]  req_done,
    output logic              req_error,
    output logic              dev_start,
    input  logic              dev_ready,
    input  logic              dev_done,
    output logic [ID_W-1:0]   grant_id,
    output logic [31:0]       grant_sec,
    output logic [31:0]       grant_nsec,
    output logic              stat_busy,
    output logic              stat_timeout
);

    localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    ARB_STATE_T      state;
    logic [ID_W-1:0] rr_ptr;
    logic [CNT_W-1:0] busy_cnt;
    logic            pick_vld;
    logic [ID_W-1:0] pick_idx;

    axi_ts_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req_start),
        .rr_ptr (rr_ptr),
        .valid  (pick_vld),
        .index  (pick_idx)
    );

    // stat_busy is written alongside every state change so it always
    // reflects whether the next state is GRANT or BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            busy_cnt     <= '0;
            req_ready    <= '0;
            req_done     <= '0;
            req_error    <= 1'b0;
            dev_start    <= 1'b0;
            grant_id     <= '0;
            grant_sec    <= '0;
            grant_nsec   <= '0;
            stat_busy    <= 1'b0;
            stat_timeout <= 1'b0;
        end else begin
            req_ready <= '0;
            req_done  <= '0;
            req_error <= 1'b0;

            if (ctrl_abort) begin
                state     <= IDLE;
                dev_start <= 1'b0;
                stat_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pick_vld) begin
                            grant_id  <= pick_idx;
                            dev_start <= 1'b1;
                            stat_busy <= 1'b1;
                            state     <= GRANT;
                        end
                    end

                    GRANT: begin
                        // Acceptance wins over a same-cycle withdraw: the
                        // device has already committed to the measurement.
                        if (dev_ready) begin
                            dev_start           <= 1'b0;
                            grant_sec           <= rtc_sec;
                            grant_nsec          <= rtc_nsec;
                            req_ready[grant_id] <= 1'b1;
                            busy_cnt            <= '0;
                            state               <= BUSY;
                        end else if (!req_start[grant_id]) begin
                            dev_start <= 1'b0;
                            stat_busy <= 1'b0;
                            state     <= IDLE;
                        end
                    end

                    BUSY: begin
                        busy_cnt <= busy_cnt + 1'b1;
                        // dev_done is checked first so it wins a tie with the timeout.
                        if (dev_done) begin
                            req_done[grant_id] <= 1'b1;
                            stat_busy          <= 1'b0;
                            state              <= RELEASE;
                        end else if (TO_EN && (busy_cnt == TO_LAST)) begin
                            req_done[grant_id] <= 1'b1;
                            req_error          <= 1'b1;
                            stat_timeout       <= 1'b1;
                            stat_busy          <= 1'b0;
                            state              <= RELEASE;
                        end
                    end

                    RELEASE: begin
                        rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                        state  <= IDLE;
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_ts_measure_arb.sv
// Self-checking bench for axi_ts_measure_arb: directed scenarios then randomized transactions.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values come from a transaction-level round-robin model kept in the bench.
module tb_axi_ts_measure_arb;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 16;

    localparam int SC_NORMAL   = 0;
    localparam int SC_TIMEOUT  = 1;
    localparam int SC_WITHDRAW = 2;
    localparam int SC_ABORT_G  = 3;
    localparam int SC_ABORT_B  = 4;

    logic          clk;
    logic          rst;
    logic [31:0]   rtc_sec;
    logic [31:0]   rtc_nsec;
    logic          ctrl_abort;
    logic [N-1:0]  req_start;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  req_done;
    logic          req_error;
    logic          dev_start;
    logic          dev_ready;
    logic          dev_done;
    logic [IW-1:0] grant_id;
    logic [31:0]   grant_sec;
    logic [31:0]   grant_nsec;
    logic          stat_busy;
    logic          stat_timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: round-robin pointer and sticky timeout flag.
    int m_ptr;
    bit m_tout;

    axi_ts_measure_arb #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rtc_sec      (rtc_sec),
        .rtc_nsec     (rtc_nsec),
        .ctrl_abort   (ctrl_abort),
        .req_start    (req_start),
        .req_ready    (req_ready),
        .req_done     (req_done),
        .req_error    (req_error),
        .dev_start    (dev_start),
        .dev_ready    (dev_ready),
        .dev_done     (dev_done),
        .grant_id     (grant_id),
        .grant_sec    (grant_sec),
        .grant_nsec   (grant_nsec),
        .stat_busy    (stat_busy),
        .stat_timeout (stat_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to the next falling edge and present a fresh RTC value.
    task automatic step();
        @(negedge clk);
        rtc_sec  = $urandom;
        rtc_nsec = $urandom;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    // First requester in mask at or after ptr, wrapping; -1 if none.
    function automatic int rr_winner(input logic [N-1:0] mask, input int ptr);
        int res;
        int c;
        res = -1;
        for (int k = 0; k < N; k++) begin
            c = (ptr + k) % N;
            if (res < 0 && mask[c[IW-1:0]]) res = c;
        end
        return res;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {req_ready, req_done, req_error, dev_start, grant_id, stat_busy, stat_timeout}, '0);
        chk({tag, "_ts"}, {grant_sec, grant_nsec}, '0);
    endtask

    // One arbitration transaction, starting with the DUT idle at a falling edge
    // and ending with it idle again. win is the model's choice, gid the observed owner.
    task automatic do_txn(input logic [N-1:0] mask, input int sc, input int r, input int d,
                          output int win, output int gid);
        int steps;
        logic [31:0] es;
        logic [31:0] en;
        win = rr_winner(mask, m_ptr);
        req_start = mask;
        step();
        gid = int'(grant_id);
        chk("grant_dev_start", dev_start, 1'b1);
        chk("grant_id", grant_id, win);
        chk("grant_busy", stat_busy, 1'b1);
        for (int i = 0; i < r; i++) begin
            dev_done = 1'($urandom_range(0, 1));   // stray done while granted must be ignored
            step();
            dev_done = 1'b0;
            chk("grant_hold", {req_ready, req_done, dev_start}, {{2*N{1'b0}}, 1'b1});
        end
        if (sc == SC_WITHDRAW) begin
            req_start = mask & ~oh(win);
            step();
            chk("withdraw", {dev_start, stat_busy, req_ready, req_done}, '0);
        end else if (sc == SC_ABORT_G) begin
            ctrl_abort = 1'b1;
            step();
            ctrl_abort = 1'b0;
            req_start  = '0;
            chk("abort_grant", {dev_start, stat_busy, req_ready, req_done}, '0);
        end else begin
            dev_ready = 1'b1;
            es = rtc_sec;
            en = rtc_nsec;
            step();
            dev_ready = 1'b0;
            req_start = '0;
            chk("ready_pulse", req_ready, oh(win));
            chk("ready_dev_start", dev_start, 1'b0);
            chk("ts_sec", grant_sec, es);
            chk("ts_nsec", grant_nsec, en);
            chk("ready_busy", stat_busy, 1'b1);
            if (sc == SC_TIMEOUT) begin
                steps = 0;
                do begin
                    step();
                    steps++;
                end while (req_done == '0 && steps < 40);
                chk("to_latency", steps, TO);
                chk("to_done", req_done, oh(win));
                chk("to_error", req_error, 1'b1);
                chk("to_sticky", stat_timeout, 1'b1);
                m_tout = 1'b1;
                m_ptr  = (win + 1) % N;
                step();
                chk("done_width", req_done, '0);
            end else begin
                for (int i = 0; i < d; i++) begin
                    dev_ready = 1'($urandom_range(0, 1));   // stray ready while busy must be ignored
                    step();
                    dev_ready = 1'b0;
                    chk("busy_hold", {req_ready, req_done}, '0);
                end
                if (sc == SC_ABORT_B) begin
                    ctrl_abort = 1'b1;
                    step();
                    ctrl_abort = 1'b0;
                    chk("abort_busy", {dev_start, stat_busy, req_ready, req_done}, '0);
                end else begin
                    dev_done = 1'b1;
                    step();
                    dev_done = 1'b0;
                    chk("done_pulse", req_done, oh(win));
                    chk("done_error", req_error, 1'b0);
                    chk("done_busy", stat_busy, 1'b0);
                    chk("done_owner", grant_id, win);
                    chk("ts_hold", {grant_sec, grant_nsec}, {es, en});
                    m_ptr = (win + 1) % N;
                    step();
                    chk("done_width", req_done, '0);
                end
            end
        end
        chk("sticky_timeout", stat_timeout, m_tout);
    endtask

    initial begin
        int w;
        int g;
        rst        = 1'b1;
        ctrl_abort = 1'b0;
        req_start  = '0;
        dev_ready  = 1'b0;
        dev_done   = 1'b0;
        rtc_sec    = '0;
        rtc_nsec   = '0;
        m_ptr      = 0;
        m_tout     = 1'b0;
        repeat (3) step();
        chk_reset("reset");
        rst = 1'b0;

        // Single requester through the full handshake.
        do_txn(4'b0010, SC_NORMAL, 3, 10, w, g);
        chk("single_owner", g, 1);

        // dev_done on the very cycle the timeout would fire: done wins.
        do_txn(4'b0100, SC_NORMAL, 0, TO - 1, w, g);
        chk("done_vs_timeout_owner", g, 2);

        // Reset while a grant is outstanding.
        req_start = 4'b0100;
        step();
        chk("pre_reset_grant", dev_start, 1'b1);
        rst       = 1'b1;
        req_start = '0;
        step();
        step();
        chk_reset("reset_mid_grant");
        rst    = 1'b0;
        m_ptr  = 0;
        m_tout = 1'b0;

        // After reset 0 beats 3; then held all-request gives 1,2,3 and wraps to 0.
        do_txn(4'b1001, SC_NORMAL, 0, 0, w, g);
        chk("rr_order0", g, 0);
        for (int i = 1; i <= 4; i++) begin
            do_txn(4'b1111, SC_NORMAL, 0, 0, w, g);
            chk("rr_order", g, i % N);
        end

        // Requester 2 withdraws; pending requester 3 is granted next.
        do_txn(4'b1100, SC_WITHDRAW, 1, 0, w, g);
        chk("withdraw_owner", g, 2);
        do_txn(4'b1000, SC_NORMAL, 0, 2, w, g);
        chk("after_withdraw_owner", g, 3);

        // Busy timeout, then the next requester proceeds normally.
        do_txn(4'b0001, SC_TIMEOUT, 1, 0, w, g);
        do_txn(4'b0011, SC_NORMAL, 0, 1, w, g);
        chk("after_timeout_owner", g, 1);

        // Abort in BUSY leaves the pointer on 2, so 2 is re-granted ahead of 1.
        do_txn(4'b0100, SC_ABORT_B, 1, 3, w, g);
        do_txn(4'b0110, SC_NORMAL, 0, 1, w, g);
        chk("after_abort_owner", g, 2);

        do_txn(4'b1000, SC_ABORT_G, 2, 0, w, g);

        for (int it = 0; it < 60; it++) begin
            do_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, TO - 1)), w, g);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
